// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter that shares one UART
// transmitter between NREQ show-ahead FIFO heads. The granted source is muxed
// onto the transmitter and the transmitter's consume pulse is turned into a
// one-cycle pop for that source only.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 0
) (
    input  logic                sclk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req_empty_i,
    input  logic [8*NREQ-1:0]   req_data_i,
    input  logic [NREQ-1:0]     req_last_i,
    output logic [NREQ-1:0]     req_rd_o,
    output logic                tx_empty_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_pop_i,
    output logic [NREQ-1:0]     grant_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic [1:0] {IDLE, SERVE, MASK, REL} state_t;

    state_t        state;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] rr_ptr;
    logic [BW-1:0] burst_cnt;

    logic [PW-1:0] sel_idx;
    logic [PW-1:0] hi_idx;
    logic          sel_valid;
    logic          hi_valid;
    logic [PW-1:0] next_ptr;
    logic          burst_hit;
    logic          rel;
    logic [7:0]    data_arr [NREQ];

    // Split the flat head-byte bus into one byte per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
            assign data_arr[gi] = req_data_i[8*gi +: 8];
        end
    endgenerate

    // Round-robin search: lowest non-empty index at or above rr_ptr wins,
    // otherwise wrap around to the lowest non-empty index overall.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        hi_valid  = 1'b0;
        hi_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (!req_empty_i[i]) begin
                sel_valid = 1'b1;
                sel_idx   = PW'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_valid = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        if (hi_valid) begin
            sel_idx = hi_idx;
        end
    end

    // Release decision, taken from the head sampled in the pop cycle itself.
    always_comb begin
        burst_hit = (MAX_BURST != 0) && ((int'(burst_cnt) + 1) == MAX_BURST);
        rel       = req_last_i[grant_idx] | burst_hit;
        next_ptr  = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end

    // Transmitter side: head of the granted source while serving; the mask and
    // release cycles hide the stale head while the source is being popped.
    always_comb begin
        tx_data_o  = busy_o ? data_arr[grant_idx] : 8'h00;
        tx_empty_o = (state == SERVE) ? req_empty_i[grant_idx] : 1'b1;
    end

    // Arbitration FSM with registered grant, pop, busy and sticky error.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            state     <= IDLE;
            grant_idx <= '0;
            grant_o   <= '0;
            busy_o    <= 1'b0;
            req_rd_o  <= '0;
            err_o     <= 1'b0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            req_rd_o <= '0;
            case (state)
                IDLE: begin
                    if (tx_pop_i) begin
                        err_o <= 1'b1;
                    end
                    if (sel_valid) begin
                        grant_o   <= NREQ'(1) << sel_idx;
                        grant_idx <= sel_idx;
                        busy_o    <= 1'b1;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (tx_pop_i) begin
                        req_rd_o <= NREQ'(1) << grant_idx;
                        if (rel) begin
                            // Grant drops in the same cycle the final pop is issued.
                            grant_o   <= '0;
                            busy_o    <= 1'b0;
                            burst_cnt <= '0;
                            rr_ptr    <= next_ptr;
                            state     <= REL;
                        end else begin
                            if (MAX_BURST != 0) begin
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                            state <= MASK;
                        end
                    end
                end
                MASK: begin
                    if (tx_pop_i) begin
                        err_o <= 1'b1;
                    end
                    state <= SERVE;
                end
                REL: begin
                    if (tx_pop_i) begin
                        err_o <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed stimulus with a scoreboard of
// expected pops checked by independent monitors, plus direct output checks.
module tb_uart_tx_arbiter;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic rstn;

    // Instance A: unlimited burst
    logic [3:0]  empty_a, last_a, rd_a, gnt_a;
    logic [31:0] data_a;
    logic        pop_a, txe_a, busy_a, err_a;
    logic [7:0]  txd_a;

    // Instance B: burst limit of 2
    logic [3:0]  empty_b, last_b, rd_b, gnt_b;
    logic [31:0] data_b;
    logic        pop_b, txe_b, busy_b, err_b;
    logic [7:0]  txd_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] rd;
        logic [7:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    uart_tx_arbiter #(.NREQ(4), .MAX_BURST(0)) dut_a (
        .sclk(sclk), .rstn(rstn),
        .req_empty_i(empty_a), .req_data_i(data_a), .req_last_i(last_a),
        .req_rd_o(rd_a), .tx_empty_o(txe_a), .tx_data_o(txd_a),
        .tx_pop_i(pop_a), .grant_o(gnt_a), .busy_o(busy_a), .err_o(err_a)
    );

    uart_tx_arbiter #(.NREQ(4), .MAX_BURST(2)) dut_b (
        .sclk(sclk), .rstn(rstn),
        .req_empty_i(empty_b), .req_data_i(data_b), .req_last_i(last_b),
        .req_rd_o(rd_b), .tx_empty_o(txe_b), .tx_data_o(txd_b),
        .tx_pop_i(pop_b), .grant_o(gnt_b), .busy_o(busy_b), .err_o(err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic set_head_a(input int k, input logic [7:0] d, input logic l, input logic e);
        data_a[8*k +: 8] = d;
        last_a[k]        = l;
        empty_a[k]       = e;
    endtask

    task automatic set_head_b(input int k, input logic [7:0] d, input logic l, input logic e);
        data_b[8*k +: 8] = d;
        last_b[k]        = l;
        empty_b[k]       = e;
    endtask

    // Issue one consume pulse and record the pop it must cause.
    task automatic pop_a_exp(input int k, input logic [7:0] d);
        exp_t x;
        x.rd   = 4'(1 << k);
        x.data = d;
        q_a.push_back(x);
        pop_a = 1'b1;
        tick();
        pop_a = 1'b0;
    endtask

    task automatic pop_b_exp(input int k, input logic [7:0] d);
        exp_t x;
        x.rd   = 4'(1 << k);
        x.data = d;
        q_b.push_back(x);
        pop_b = 1'b1;
        tick();
        pop_b = 1'b0;
    endtask

    // Monitor A: every req_rd_o pulse must match the next expected pop and the
    // byte presented to the transmitter in the consume cycle.
    logic [7:0] cap_a;
    always @(negedge sclk) begin
        exp_t e;
        if (rd_a != 4'b0) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL pop_a_extra: got rd=%b expected no pop", rd_a);
            end else begin
                e = q_a.pop_front();
                if (rd_a !== e.rd || cap_a !== e.data) begin
                    errors++;
                    $display("FAIL pop_a: got rd=%b data=%h expected rd=%b data=%h",
                             rd_a, cap_a, e.rd, e.data);
                end else begin
                    $display("A xfer rd=%b data=%h", rd_a, cap_a);
                end
            end
        end
        if (pop_a) cap_a = txd_a;
    end

    // Monitor B: same scoreboard for the burst-limited instance.
    logic [7:0] cap_b;
    always @(negedge sclk) begin
        exp_t e;
        if (rd_b != 4'b0) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL pop_b_extra: got rd=%b expected no pop", rd_b);
            end else begin
                e = q_b.pop_front();
                if (rd_b !== e.rd || cap_b !== e.data) begin
                    errors++;
                    $display("FAIL pop_b: got rd=%b data=%h expected rd=%b data=%h",
                             rd_b, cap_b, e.rd, e.data);
                end else begin
                    $display("B xfer rd=%b data=%h", rd_b, cap_b);
                end
            end
        end
        if (pop_b) cap_b = txd_b;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rstn    = 1'b0;
        pop_a   = 1'b0;
        pop_b   = 1'b0;
        empty_a = 4'hF;
        empty_b = 4'hF;
        last_a  = 4'h0;
        last_b  = 4'h0;
        data_a  = 32'h0;
        data_b  = 32'h0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset values on both instances
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_txe_a", txe_a, 1);
        chk("rst_txd_a", txd_a, 0);
        chk("rst_err_b", err_b, 0);
        chk("rst_txe_b", txe_b, 1);
        chk("rst_busy_b", busy_b, 0);

        // Reset asserted mid-SERVE after two pops
        set_head_a(0, 8'hA0, 1'b0, 1'b0);
        tick();
        chk("t1_grant0", gnt_a, 4'b0001);
        pop_a_exp(0, 8'hA0);
        set_head_a(0, 8'hA1, 1'b0, 1'b0);
        tick();
        pop_a_exp(0, 8'hA1);
        set_head_a(0, 8'hA2, 1'b0, 1'b0);
        tick();
        chk("t1_busy_pre", busy_a, 1);
        rstn    = 1'b0;
        empty_a = 4'hF;
        tick();
        rstn = 1'b1;
        chk("t1_rst_gnt", gnt_a, 0);
        chk("t1_rst_busy", busy_a, 0);
        chk("t1_rst_err", err_a, 0);
        chk("t1_rst_txe", txe_a, 1);
        chk("t1_rst_txd", txd_a, 0);
        chk("t1_rst_rd", rd_a, 0);
        set_head_a(2, 8'h5C, 1'b1, 1'b0);
        tick();
        chk("t1_grant2", gnt_a, 4'b0100);
        chk("t1_txe", txe_a, 0);
        chk("t1_txd", txd_a, 8'h5C);
        pop_a_exp(2, 8'h5C);
        chk("t1_rel_gnt", gnt_a, 0);
        chk("t1_rel_txe", txe_a, 1);
        empty_a[2] = 1'b1;
        tick();
        tick();
        chk("t1_idle_gnt", gnt_a, 0);

        // Round-robin order from a fresh pointer
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_head_a(k, 8'(8'h10 + 17 * k), 1'b1, 1'b0);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_gnt", gnt_a, 32'(1 << k));
            chk("t2_txd", txd_a, 32'(8'h10 + 17 * k));
            pop_a_exp(k, 8'(8'h10 + 17 * k));
            empty_a[k] = 1'b1;
            tick();
            tick();
        end
        chk("t2_end_gnt", gnt_a, 0);
        chk("t2_end_busy", busy_a, 0);

        // Packet lock: requester 1 keeps the grant for 3 bytes
        set_head_a(1, 8'hB1, 1'b0, 1'b0);
        tick();
        chk("t3_gnt1", gnt_a, 4'b0010);
        set_head_a(0, 8'h0D, 1'b1, 1'b0);
        pop_a_exp(1, 8'hB1);
        chk("t3_mask_gnt", gnt_a, 4'b0010);
        chk("t3_mask_txe", txe_a, 1);
        set_head_a(1, 8'hB2, 1'b0, 1'b0);
        tick();
        chk("t3_gnt_b2", gnt_a, 4'b0010);
        chk("t3_txe_b2", txe_a, 0);
        chk("t3_txd_b2", txd_a, 8'hB2);
        pop_a_exp(1, 8'hB2);
        set_head_a(1, 8'hB3, 1'b1, 1'b0);
        tick();
        chk("t3_gnt_b3", gnt_a, 4'b0010);
        pop_a_exp(1, 8'hB3);
        chk("t3_rel_gnt", gnt_a, 0);
        empty_a[1] = 1'b1;
        tick();
        chk("t3_idle_gnt", gnt_a, 0);
        tick();
        chk("t3_gnt0", gnt_a, 4'b0001);
        chk("t3_txd0", txd_a, 8'h0D);
        pop_a_exp(0, 8'h0D);
        empty_a[0] = 1'b1;
        tick();
        tick();

        // Mask timing and spurious pop during MASK
        set_head_a(2, 8'hE0, 1'b0, 1'b0);
        tick();
        chk("t5_gnt2", gnt_a, 4'b0100);
        chk("t5_err_pre", err_a, 0);
        begin
            exp_t x;
            x.rd   = 4'b0100;
            x.data = 8'hE0;
            q_a.push_back(x);
        end
        pop_a = 1'b1;
        tick();
        chk("t5_rd_m1", rd_a, 4'b0100);
        chk("t5_txe_m1", txe_a, 1);
        set_head_a(2, 8'hE1, 1'b1, 1'b0);
        tick();
        pop_a = 1'b0;
        chk("t5_rd_m2", rd_a, 0);
        chk("t5_err", err_a, 1);
        chk("t5_txd", txd_a, 8'hE1);
        pop_a_exp(2, 8'hE1);
        empty_a[2] = 1'b1;
        tick();
        tick();
        chk("t5_err_sticky", err_a, 1);

        // Mid-packet underflow holds the grant
        set_head_a(0, 8'h60, 1'b0, 1'b0);
        tick();
        chk("t6_gnt0", gnt_a, 4'b0001);
        set_head_a(3, 8'h7E, 1'b1, 1'b0);
        pop_a_exp(0, 8'h60);
        empty_a[0] = 1'b1;
        tick();
        chk("t6_uf_txe", txe_a, 1);
        chk("t6_uf_gnt", gnt_a, 4'b0001);
        tick();
        chk("t6_uf_gnt2", gnt_a, 4'b0001);
        set_head_a(0, 8'h61, 1'b1, 1'b0);
        tick();
        chk("t6_refill_txe", txe_a, 0);
        chk("t6_refill_txd", txd_a, 8'h61);
        pop_a_exp(0, 8'h61);
        empty_a[0] = 1'b1;
        tick();
        tick();
        chk("t6_gnt3", gnt_a, 4'b1000);
        chk("t6_txd3", txd_a, 8'h7E);
        pop_a_exp(3, 8'h7E);
        empty_a[3] = 1'b1;
        tick();
        tick();

        // Burst limit of 2 on instance B
        set_head_b(0, 8'hC0, 1'b0, 1'b0);
        tick();
        chk("t4_gnt0", gnt_b, 4'b0001);
        pop_b_exp(0, 8'hC0);
        chk("t4_mask_gnt", gnt_b, 4'b0001);
        set_head_b(0, 8'hC1, 1'b0, 1'b0);
        tick();
        pop_b_exp(0, 8'hC1);
        chk("t4_rel_gnt", gnt_b, 0);
        chk("t4_rel_busy", busy_b, 0);
        chk("t4_rr_ptr", 32'(dut_b.rr_ptr), 1);
        set_head_b(0, 8'hC2, 1'b0, 1'b0);
        tick();
        tick();
        chk("t4_regrant", gnt_b, 4'b0001);
        chk("t4_txd", txd_b, 8'hC2);
        pop_b_exp(0, 8'hC2);
        set_head_b(0, 8'hC3, 1'b0, 1'b0);
        tick();
        pop_b_exp(0, 8'hC3);
        chk("t4_rel2_gnt", gnt_b, 0);
        tick();
        tick();

        chk("q_a_drained", 32'(q_a.size()), 0);
        chk("q_b_drained", 32'(q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
